// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to the icache
// and queues {instruction, pc} pairs in a small in-order FIFO toward decode.
module ifu_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h3000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             fetch_rreq_o,
    output logic [WIDTH-1:0] fetch_raddr_o,
    input  logic             fetch_rready_i,
    input  logic             fetch_rvalid_i,
    input  logic [WIDTH-1:0] fetch_rdata_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_inst_o,
    output logic [WIDTH-1:0] out_pc_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             issue;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_pc;
    logic [WIDTH-1:0] target;
    logic             redirect_low_unused;

    assign target              = {redirect_pc_i[WIDTH-1:2], 2'b00};
    assign redirect_low_unused = ^redirect_pc_i[1:0];

    // A request is a single-cycle pulse; the icache keeps its own MSHR afterwards.
    assign issue = (state == IDLE) && (count < FULL) && fetch_rready_i
                   && !redirect_valid_i && !reset;

    assign push = (issue && fetch_rvalid_i)
                  || ((state == WAIT) && fetch_rvalid_i && !redirect_valid_i && !reset);
    assign push_pc = (state == IDLE) ? pc : req_addr;
    assign pop     = out_valid_o && out_ready_i;

    assign fetch_rreq_o  = issue;
    assign fetch_raddr_o = (state == IDLE) ? pc : req_addr;
    assign out_valid_o   = (count != '0);
    assign out_inst_o    = inst_mem[head];
    assign out_pc_o      = pc_mem[head];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid_i) begin
            pc    <= target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            case (state)
                IDLE:    state <= IDLE;
                default: state <= fetch_rvalid_i ? IDLE : DROP;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (fetch_rvalid_i) begin
                            pc <= pc + STEP;
                        end else begin
                            req_addr <= pc;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (fetch_rvalid_i) begin
                        pc    <= req_addr + STEP;
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (fetch_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[tail] <= fetch_rdata_i;
            pc_mem[tail]   <= push_pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: an icache model drives the fetch port and a
// scoreboard checks the decode stream against the expected sequential PC order.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock;
    logic        reset;
    logic        fetch_rreq_o;
    logic [31:0] fetch_raddr_o;
    logic        fetch_rready_i;
    logic        fetch_rvalid_i;
    logic [31:0] fetch_rdata_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;

    ifu_fetch #(.WIDTH(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_rreq_o     (fetch_rreq_o),
        .fetch_raddr_o    (fetch_raddr_o),
        .fetch_rready_i   (fetch_rready_i),
        .fetch_rvalid_i   (fetch_rvalid_i),
        .fetch_rdata_i    (fetch_rdata_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_inst_o       (out_inst_o),
        .out_pc_o         (out_pc_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Stimulus knobs
    int hit_pct, min_lat, max_lat, rdy_pct, rr_pct, redir_pct, rst_pmil;
    bit phase_b;

    // icache / architectural model state
    bit          outstanding, stale;
    logic [31:0] out_addr, nf_addr, tail_pc;
    int          cnt;
    bit          prev_push, prev_redir, prev_reset, prev_resp_ok;
    int          req_cnt, ov_cnt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0413;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected decode stream restarts at a new PC and continues sequentially.
    task automatic flush(input logic [31:0] a);
        exp_q.delete();
        tail_pc = a;
        nf_addr = a;
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: tail_pc, inst: memf(tail_pc)});
            tail_pc = tail_pc + 32'd4;
        end
    endtask

    function automatic logic [31:0] pick_target();
        int r;
        r = int'($urandom_range(9));
        if (r == 0) return 32'hFFFF_FFF4 | 32'($urandom_range(3));
        if (r == 1) return 32'h3000_0102;
        return 32'h3000_0000 | ($urandom & 32'h0000_0FFF);
    endfunction

    task automatic cycle(input bit force_reset);
        bit          rst_v, rd_v, resp, hit, blocked;
        logic [31:0] tgt;
        int          lat;
        @(posedge clock);
        #1;
        rst_v = force_reset || ($urandom_range(999) < rst_pmil);
        rd_v  = !rst_v && ($urandom_range(99) < redir_pct);
        tgt   = pick_target();
        reset            = rst_v;
        redirect_valid_i = rd_v;
        redirect_pc_i    = tgt;
        out_ready_i      = ($urandom_range(99) < rdy_pct);
        fetch_rready_i   = !outstanding && ($urandom_range(99) < rr_pct);
        fetch_rvalid_i   = 1'b0;
        fetch_rdata_i    = $urandom;
        resp = 1'b0;
        hit  = 1'b0;
        if (outstanding) begin
            if (cnt == 0) begin
                resp           = 1'b1;
                fetch_rvalid_i = 1'b1;
                fetch_rdata_i  = memf(out_addr);
            end else begin
                cnt--;
            end
        end
        #1;
        if (prev_reset) begin
            chk("reset_out_valid", 32'(out_valid_o), 32'd0);
            chk("reset_raddr", fetch_raddr_o, RST_PC);
        end
        if (prev_redir) chk("redirect_flush", 32'(out_valid_o), 32'd0);
        if (prev_push) chk("push_to_valid", 32'(out_valid_o), 32'd1);
        if (phase_b && prev_resp_ok && !rd_v && !rst_v)
            chk("miss_reissue", 32'(fetch_rreq_o), 32'd1);
        if (out_valid_o) ov_cnt++;
        if (outstanding) chk("raddr_hold", fetch_raddr_o, out_addr);
        blocked = rst_v || rd_v || !fetch_rready_i;
        if (blocked) begin
            chk("req_blocked", 32'(fetch_rreq_o), 32'd0);
        end else if (fetch_rreq_o) begin
            chk("fetch_addr", fetch_raddr_o, nf_addr);
            req_cnt++;
            nf_addr = nf_addr + 32'd4;
            lat = ($urandom_range(99) < hit_pct) ? 0 : int'($urandom_range(max_lat, min_lat));
            if (lat == 0) begin
                hit            = 1'b1;
                fetch_rvalid_i = 1'b1;
                fetch_rdata_i  = memf(fetch_raddr_o);
            end else begin
                outstanding = 1'b1;
                stale       = 1'b0;
                out_addr    = fetch_raddr_o;
                cnt         = lat - 1;
            end
        end
        prev_push    = !rst_v && !rd_v && (hit || (resp && !stale));
        prev_resp_ok = !rst_v && !rd_v && resp && !stale;
        prev_redir   = rd_v;
        prev_reset   = rst_v;
        if (resp) outstanding = 1'b0;
        if (rst_v) begin
            outstanding = 1'b0;
            stale       = 1'b0;
            flush(RST_PC);
        end else if (rd_v) begin
            if (outstanding) stale = 1'b1;
            flush({tgt[31:2], 2'b00});
        end
        topup();
    endtask

    // Monitor: every accepted head entry must match the next expected one.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && !redirect_valid_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc %h expected none", out_pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc_o, e.pc);
                chk("out_inst", out_inst_o, e.inst);
            end
        end
    end

    task automatic set_mode(input int hp, input int mn, input int mx, input int rdy,
                            input int rr, input int rd, input int rs);
        hit_pct = hp; min_lat = mn; max_lat = mx; rdy_pct = rdy;
        rr_pct = rr; redir_pct = rd; rst_pmil = rs;
    endtask

    initial begin
        reset = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        out_ready_i = 1'b0; fetch_rready_i = 1'b0; fetch_rvalid_i = 1'b0;
        fetch_rdata_i = '0;
        outstanding = 0; stale = 0; out_addr = '0; cnt = 0;
        prev_push = 0; prev_redir = 0; prev_reset = 0; prev_resp_ok = 0;
        req_cnt = 0; ov_cnt = 0; phase_b = 0;
        set_mode(100, 1, 1, 100, 100, 0, 0);
        flush(RST_PC);
        topup();

        // Back-to-back hits: one instruction per cycle after the first request
        repeat (3) cycle(1'b1);
        cycle(1'b0);
        ov_cnt = 0;
        repeat (39) cycle(1'b0);
        chk("hit_throughput", 32'(ov_cnt), 32'd39);

        // Fixed 5-cycle misses from reset
        repeat (2) cycle(1'b1);
        set_mode(0, 5, 5, 100, 100, 0, 0);
        phase_b = 1'b1;
        repeat (40) cycle(1'b0);
        phase_b = 1'b0;

        // Drain, then stall decode: exactly DEPTH fetches are accepted
        set_mode(100, 1, 1, 100, 0, 0, 0);
        repeat (10) cycle(1'b0);
        chk("drained", 32'(out_valid_o), 32'd0);
        set_mode(100, 1, 1, 0, 100, 0, 0);
        req_cnt = 0;
        repeat (8) cycle(1'b0);
        chk("stall_accept", 32'(req_cnt), 32'd2);
        chk("stall_full", 32'(out_valid_o), 32'd1);
        set_mode(100, 1, 1, 100, 100, 0, 0);
        repeat (12) cycle(1'b0);

        // Random mix of hits, misses, back-pressure, redirects and resets
        set_mode(50, 1, 6, 75, 85, 6, 3);
        repeat (3000) cycle(1'b0);

        set_mode(100, 1, 1, 100, 0, 0, 0);
        repeat (12) cycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
